// File: rtl/rfid_tx_sequencer.sv
// rfid_tx_sequencer
//   Builds a 64-bit EM4100-style frame from a 40-bit tag ID and shifts it out
//   MSB-first toward the man_mod Manchester modulator, one bit every
//   BIT_CYCLES clocks. Frames can repeat with a silent gap of GAP_BITS bit
//   periods between them. A transmission can be aborted at any time.
//
// Ports
//   clk, rst     : system clock, asynchronous active-high reset
//   start        : one-cycle request, honoured only while idle
//   abort        : synchronous abort, beats every input except rst
//   repeat_en    : keep re-sending the latched frame while high
//   id_data[39:0]: tag ID, captured when start is accepted
//   busy         : not idle
//   done         : one-cycle pulse when the final frame has been sent
//   mod_enable   : man_mod in_enable, high while frame bits are on the wire
//   mod_data     : man_mod in_data, current frame bit (0 when disabled)
//   bit_strobe   : pulse on the first cycle of every transmitted bit
module rfid_tx_sequencer #(
  parameter int unsigned BIT_CYCLES = 16,
  parameter int unsigned GAP_BITS   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        repeat_en,
  input  logic [39:0] id_data,
  output logic        busy,
  output logic        done,
  output logic        mod_enable,
  output logic        mod_data,
  output logic        bit_strobe
);

  localparam int unsigned CYC_W   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned GAP_LEN = GAP_BITS * BIT_CYCLES;
  localparam int unsigned GAP_W   = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_e;

  state_e           state_q, state_d;
  logic [63:0]      frame_q, frame_d;
  logic [CYC_W-1:0] cyc_q,   cyc_d;
  logic [5:0]       bit_q,   bit_d;
  logic [GAP_W-1:0] gap_q,   gap_d;

  logic busy_q,       busy_d;
  logic done_q,       done_d;
  logic mod_enable_q, mod_enable_d;
  logic mod_data_q,   mod_data_d;
  logic bit_strobe_q, bit_strobe_d;

  // Header of nine ones, ten rows of {nibble, even parity}, four column
  // parities, stop bit 0.
  function automatic logic [63:0] build_frame(input logic [39:0] id);
    logic [63:0] f;
    logic [3:0]  nib;
    logic [3:0]  col;
    f        = '0;
    col      = '0;
    f[63:55] = '1;
    for (int unsigned r = 0; r < 10; r++) begin
      nib = id[39 - 4*r -: 4];
      f[54 - 5*r -: 5] = {nib, ^nib};
      col = col ^ nib;
    end
    f[4:1] = col;
    f[0]   = 1'b0;
    return f;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      frame_q      <= '0;
      cyc_q        <= '0;
      bit_q        <= '0;
      gap_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mod_enable_q <= 1'b0;
      mod_data_q   <= 1'b0;
      bit_strobe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      cyc_q        <= cyc_d;
      bit_q        <= bit_d;
      gap_q        <= gap_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mod_enable_q <= mod_enable_d;
      mod_data_q   <= mod_data_d;
      bit_strobe_q <= bit_strobe_d;
    end
  end

  // Next state and counters
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    if (abort) begin
      state_d = IDLE;
      cyc_d   = '0;
      bit_d   = '0;
      gap_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = SEND;
            frame_d = build_frame(id_data);
            cyc_d   = '0;
            bit_d   = 6'd63;
          end
        end
        SEND: begin
          if (cyc_q == CYC_LAST) begin
            cyc_d = '0;
            if (bit_q == 6'd0) begin
              gap_d   = '0;
              state_d = repeat_en ? GAP : IDLE;
            end else begin
              bit_d = bit_q - 6'd1;
            end
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            gap_d = '0;
            if (repeat_en) begin
              state_d = SEND;
              cyc_d   = '0;
              bit_d   = 6'd63;
            end else begin
              state_d = IDLE;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so that the registered copies
  // line up with the state they describe (bit 63 appears the cycle after start).
  always_comb begin
    busy_d       = (state_d != IDLE);
    mod_enable_d = (state_d == SEND);
    mod_data_d   = mod_enable_d & frame_d[bit_d];
    bit_strobe_d = mod_enable_d && (cyc_d == '0);
    done_d       = !abort && (state_q != IDLE) && (state_d == IDLE);
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign mod_enable = mod_enable_q;
  assign mod_data   = mod_data_q;
  assign bit_strobe = bit_strobe_q;

endmodule

// File: tb/tb_rfid_tx_sequencer.sv
module tb_rfid_tx_sequencer;

  localparam int BC = 16;
  localparam int GB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        repeat_en;
  logic [39:0] id_data;
  logic        busy, done, mod_enable, mod_data, bit_strobe;

  int checks   = 0;
  int failures = 0;
  int cyc_cnt  = 0;

  rfid_tx_sequencer #(.BIT_CYCLES(BC), .GAP_BITS(GB)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .repeat_en  (repeat_en),
    .id_data    (id_data),
    .busy       (busy),
    .done       (done),
    .mod_enable (mod_enable),
    .mod_data   (mod_data),
    .bit_strobe (bit_strobe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  // Scoreboard queues: expected bits pushed at stimulus, observed bits at strobes
  logic exp_q[$];
  logic obs_q[$];
  int   en_cnt, strobe_cnt, done_cnt, gap_cnt, hold_err, zero_err;
  int   last_done_cyc, last_strobe_cyc;
  logic cur_bit;

  always @(negedge clk) begin
    if (mod_enable) en_cnt++;
    if (busy && !mod_enable) gap_cnt++;
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc_cnt;
    end
    if (bit_strobe) begin
      strobe_cnt++;
      last_strobe_cyc = cyc_cnt;
      obs_q.push_back(mod_data);
      cur_bit = mod_data;
      if (!mod_enable) hold_err++;
    end else if (mod_enable && mod_data !== cur_bit) begin
      hold_err++;
    end
    if (!mod_enable && mod_data !== 1'b0) zero_err++;
  end

  function automatic logic [63:0] model_frame(input logic [39:0] id);
    logic [63:0] f   = '0;
    logic [3:0]  col = '0;
    logic [39:0] sh  = id;
    logic [3:0]  nib;
    for (int i = 0; i < 9; i++) f = {f[62:0], 1'b1};
    for (int r = 0; r < 10; r++) begin
      nib = sh[39:36];
      sh  = sh << 4;
      for (int k = 3; k >= 0; k--) begin
        f      = {f[62:0], nib[k]};
        col[k] = col[k] ^ nib[k];
      end
      f = {f[62:0], nib[3] ^ nib[2] ^ nib[1] ^ nib[0]};
    end
    for (int k = 3; k >= 0; k--) f = {f[62:0], col[k]};
    f = {f[62:0], 1'b0};
    return f;
  endfunction

  function automatic logic [63:0] pop_exp();
    logic [63:0] w = 'x;
    for (int i = 63; i >= 0; i--) if (exp_q.size() > 0) w[i] = exp_q.pop_front();
    return w;
  endfunction

  function automatic logic [63:0] pop_obs();
    logic [63:0] w = 'x;
    for (int i = 63; i >= 0; i--) if (obs_q.size() > 0) w[i] = obs_q.pop_front();
    return w;
  endfunction

  task automatic push_frame(input logic [63:0] f);
    for (int i = 63; i >= 0; i--) exp_q.push_back(f[i]);
  endtask

  task automatic clear_stats();
    exp_q.delete();
    obs_q.delete();
    en_cnt = 0; strobe_cnt = 0; done_cnt = 0; gap_cnt = 0;
    hold_err = 0; zero_err = 0; last_done_cyc = 0; last_strobe_cyc = 0;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Drives a one-cycle start; s_cyc is the cycle in which start is sampled.
  task automatic pulse_start(input logic [39:0] id, output int s_cyc);
    id_data = id;
    start   = 1'b1;
    s_cyc   = cyc_cnt;
    step();
    start   = 1'b0;
  endtask

  task automatic wait_done(input int base, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (done_cnt > base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_strobes(input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (strobe_cnt >= n) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    start = 0; abort = 0; repeat_en = 0; id_data = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({busy, done, mod_enable, mod_data, bit_strobe} !== 5'b0) begin
      failures++;
      $display("FAIL reset_in: outputs=%b want 00000", {busy, done, mod_enable, mod_data, bit_strobe});
    end
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();
    checks++;
    if ({busy, done, mod_enable, mod_data, bit_strobe} !== 5'b0) begin
      failures++;
      $display("FAIL reset_out: outputs=%b want 00000", {busy, done, mod_enable, mod_data, bit_strobe});
    end
  endtask

  task automatic test_zero_id();
    int s; bit ok; logic [63:0] e, o;
    clear_stats();
    push_frame(model_frame(40'h0));
    pulse_start(40'h0, s);
    checks++;
    if ({busy, mod_enable, bit_strobe, mod_data} !== 4'b1111) begin
      failures++;
      $display("FAIL zero_first_cycle: busy,en,strobe,data=%b want 1111", {busy, mod_enable, bit_strobe, mod_data});
    end
    wait_done(0, 1200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL zero_timeout: no done within 1200 cycles"); end
    checks++;
    if ({mod_enable, busy} !== 2'b00) begin
      failures++;
      $display("FAIL zero_done_cycle: en,busy=%b want 00", {mod_enable, busy});
    end
    e = pop_exp(); o = pop_obs();
    checks++;
    if (o !== e || o !== 64'hFF80_0000_0000_0000) begin
      failures++;
      $display("FAIL zero_frame: got %h want %h", o, e);
    end
    checks++;
    if (en_cnt !== 64 * BC) begin failures++; $display("FAIL zero_en_cycles: got %0d want %0d", en_cnt, 64 * BC); end
    checks++;
    if (strobe_cnt !== 64) begin failures++; $display("FAIL zero_strobes: got %0d want 64", strobe_cnt); end
    checks++;
    if (last_done_cyc - s !== 64 * BC + 1) begin
      failures++;
      $display("FAIL zero_done_time: got %0d want %0d", last_done_cyc - s, 64 * BC + 1);
    end
    step(); step();
    checks++;
    if (done_cnt !== 1 || hold_err !== 0 || zero_err !== 0 || done !== 1'b0) begin
      failures++;
      $display("FAIL zero_misc: done_cnt=%0d hold_err=%0d zero_err=%0d done=%b want 1 0 0 0",
               done_cnt, hold_err, zero_err, done);
    end
  endtask

  task automatic test_patterns();
    logic [39:0] ids[4];
    int s; bit ok; logic [63:0] e, o;
    ids[0] = 40'h00_0000_0001;
    ids[1] = 40'hFF_FFFF_FFFF;
    ids[2] = {8'($urandom), 32'($urandom)};
    ids[3] = 40'h12_3456_789A;
    for (int t = 0; t < 4; t++) begin
      clear_stats();
      push_frame(model_frame(ids[t]));
      pulse_start(ids[t], s);
      wait_done(0, 1200, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL pattern%0d_timeout: no done", t); end
      e = pop_exp(); o = pop_obs();
      checks++;
      if (o !== e) begin failures++; $display("FAIL pattern%0d_frame: got %h want %h", t, o, e); end
      if (t == 0) begin
        checks++;
        if (o !== 64'hFF80_0000_0000_0062) begin
          failures++; $display("FAIL id1_const: got %h want ff80000000000062", o);
        end
        checks++;
        if (o[5] !== 1'b1 || o[1] !== 1'b1) begin
          failures++; $display("FAIL id1_row9par_c0: got %b%b want 11", o[5], o[1]);
        end
      end
      if (t == 1) begin
        checks++;
        if (o !== 64'hFFFB_DEF7_BDEF_7BC0 || o[4:0] !== 5'b0 || o[63:55] !== 9'h1FF) begin
          failures++; $display("FAIL ones_frame: got %h want fffbdef7bdef7bc0", o);
        end
      end
      step(); step();
    end
  endtask

  task automatic test_busy_start();
    int s, s2; bit ok; logic [63:0] e, o;
    logic [39:0] a = 40'hA5_5A0F_F0C3;
    clear_stats();
    push_frame(model_frame(a));
    pulse_start(a, s);
    wait_strobes(10, 400, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL busy_start_wait: strobes=%0d want 10", strobe_cnt); end
    pulse_start(40'h11_2233_4455, s2);
    wait_done(0, 1200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL busy_start_timeout: no done"); end
    e = pop_exp(); o = pop_obs();
    checks++;
    if (o !== e) begin failures++; $display("FAIL busy_start_frame: got %h want %h", o, e); end
    checks++;
    if (en_cnt !== 64 * BC || strobe_cnt !== 64) begin
      failures++; $display("FAIL busy_start_len: en=%0d strobes=%0d want %0d 64", en_cnt, strobe_cnt, 64 * BC);
    end
    repeat (5) step();
    checks++;
    if (busy !== 1'b0 || done_cnt !== 1) begin
      failures++; $display("FAIL busy_start_after: busy=%b done_cnt=%0d want 0 1", busy, done_cnt);
    end
  endtask

  task automatic test_repeat();
    int s; bit ok; logic [63:0] e, o1, o2;
    logic [39:0] a = 40'h3C_9E01_7D42;
    clear_stats();
    push_frame(model_frame(a));
    push_frame(model_frame(a));
    repeat_en = 1'b1;
    pulse_start(a, s);
    ok = 1'b0;
    for (int i = 0; i < 1300; i++) begin
      if (obs_q.size() >= 65) begin ok = 1'b1; break; end
      step();
    end
    checks++;
    if (!ok || done_cnt !== 0) begin
      failures++; $display("FAIL repeat_second_start: started=%b done_cnt=%0d want 1 0", ok, done_cnt);
    end
    repeat_en = 1'b0;
    wait_done(0, 1200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL repeat_timeout: no done"); end
    e = pop_exp(); o1 = pop_obs();
    checks++;
    if (o1 !== e) begin failures++; $display("FAIL repeat_frame1: got %h want %h", o1, e); end
    e = pop_exp(); o2 = pop_obs();
    checks++;
    if (o2 !== e) begin failures++; $display("FAIL repeat_frame2: got %h want %h", o2, e); end
    checks++;
    if (en_cnt !== 128 * BC || gap_cnt !== GB * BC) begin
      failures++; $display("FAIL repeat_lengths: en=%0d gap=%0d want %0d %0d", en_cnt, gap_cnt, 128 * BC, GB * BC);
    end
    checks++;
    if (last_done_cyc - s !== 128 * BC + GB * BC + 1) begin
      failures++; $display("FAIL repeat_done_time: got %0d want %0d", last_done_cyc - s, 128 * BC + GB * BC + 1);
    end
    repeat (5) step();
    checks++;
    if (done_cnt !== 1 || busy !== 1'b0) begin
      failures++; $display("FAIL repeat_done_count: done_cnt=%0d busy=%b want 1 0", done_cnt, busy);
    end
  endtask

  task automatic test_abort();
    int s; bit ok; int en_snap; logic [63:0] e, o;
    logic [39:0] b = 40'h0F_1E2D_3C4B;
    clear_stats();
    pulse_start(40'h77_8899_AABB, s);
    wait_strobes(44, 1200, ok);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({mod_enable, busy, bit_strobe, mod_data} !== 4'b0000 || obs_q.size() !== 44) begin
      failures++;
      $display("FAIL abort_outputs: en,busy,strobe,data=%b bits=%0d want 0000 44",
               {mod_enable, busy, bit_strobe, mod_data}, obs_q.size());
    end
    repeat (100) step();
    checks++;
    if (done_cnt !== 0 || busy !== 1'b0) begin
      failures++; $display("FAIL abort_no_done: done_cnt=%0d busy=%b want 0 0", done_cnt, busy);
    end
    en_snap = en_cnt;
    id_data = b; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    repeat (3) step();
    checks++;
    if (busy !== 1'b0 || en_cnt !== en_snap) begin
      failures++; $display("FAIL start_with_abort: busy=%b en_delta=%0d want 0 0", busy, en_cnt - en_snap);
    end
    clear_stats();
    push_frame(model_frame(b));
    pulse_start(b, s);
    wait_done(0, 1200, ok);
    e = pop_exp(); o = pop_obs();
    checks++;
    if (!ok || o !== e || strobe_cnt !== 64) begin
      failures++; $display("FAIL abort_restart: got %h strobes=%0d want %h 64", o, strobe_cnt, e);
    end
  endtask

  task automatic test_reset_mid();
    int s; bit ok;
    clear_stats();
    pulse_start(40'hDE_AD00_BEEF, s);
    wait_strobes(30, 1200, ok);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, mod_enable, mod_data, bit_strobe} !== 5'b0) begin
      failures++;
      $display("FAIL reset_mid_async: outputs=%b want 00000", {busy, done, mod_enable, mod_data, bit_strobe});
    end
    step();
    rst = 1'b0;
    en_cnt = 0;
    repeat (40) step();
    checks++;
    if (busy !== 1'b0 || en_cnt !== 0 || done_cnt !== 0) begin
      failures++; $display("FAIL reset_mid_idle: busy=%b en=%0d done_cnt=%0d want 0 0 0", busy, en_cnt, done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int s, s2; bit ok; logic [63:0] e, o;
    logic [39:0] a = 40'h55_AA55_AA55;
    logic [39:0] b = 40'h01_2345_6789;
    clear_stats();
    push_frame(model_frame(a));
    pulse_start(a, s);
    wait_done(0, 1200, ok);
    push_frame(model_frame(b));
    pulse_start(b, s2);
    checks++;
    if (!ok || bit_strobe !== 1'b1 || mod_enable !== 1'b1 || last_strobe_cyc - last_done_cyc !== 1) begin
      failures++;
      $display("FAIL b2b_restart: strobe=%b en=%b gap=%0d want 1 1 1",
               bit_strobe, mod_enable, last_strobe_cyc - last_done_cyc);
    end
    wait_done(1, 1200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_timeout: no second done"); end
    e = pop_exp(); o = pop_obs();
    checks++;
    if (o !== e) begin failures++; $display("FAIL b2b_frame1: got %h want %h", o, e); end
    e = pop_exp(); o = pop_obs();
    checks++;
    if (o !== e) begin failures++; $display("FAIL b2b_frame2: got %h want %h", o, e); end
  endtask

  initial begin
    test_reset();
    test_zero_id();
    test_patterns();
    test_busy_start();
    test_repeat();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rfid_tx_sequencer.md
Name: rfid_tx_sequencer

Overview:
Frame sequencer that drives the man_mod Manchester modulator of the RFID tag path. On a start request it builds a 64-bit EM4100-style frame from a 40-bit tag ID and shifts it out MSB-first, one bit per BIT_CYCLES clocks. Its mod_enable and mod_data outputs connect directly to man_mod's in_enable and in_data. It supports repeated frame transmission with an inter-frame silence gap, and abort.

Parameters:
BIT_CYCLES, 16, clock cycles each frame bit is held on mod_data (≥2)
GAP_BITS, 4, bit periods of silence (mod_enable=0) between repeated frames (≥1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
abort  input  1  synchronous abort; priority over all other inputs except rst
repeat_en  input  1  when 1, frames repeat continuously with gaps until repeat_en=0 or abort
id_data  input  40  tag ID; latched on accepted start
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the final bit of the last frame
mod_enable  output  1  to man_mod in_enable; high only while frame bits are being sent
mod_data  output  1  to man_mod in_data; current frame bit, 0 when mod_enable=0
bit_strobe  output  1  one-cycle pulse on the first cycle of each transmitted bit

Behaviour:
- All outputs are registered. Reset (async, rst=1) clears state to IDLE and all outputs, counters and the frame register to 0.
- Frame build (on accepted start, from latched id_data):
  - bits[63:55] = 9'h1FF (header).
  - Row r=0..9 occupies bits[54-5r : 50-5r] = {id_data[39-4r -: 4], ^nibble} (even row parity).
  - bits[4:1] = column parities c3..c0, where cK = XOR of bit K of all 10 nibbles.
  - bits[0] = 0 (stop bit).
- States: IDLE, SEND, GAP.
- IDLE:
  - start=1 and abort=0 → latch frame, go to SEND.
  - In the next cycle (cycle 1): mod_enable=1, mod_data=frame[63], bit_strobe=1.
- SEND:
  - cyc_cnt counts 0..BIT_CYCLES-1; bit_idx counts 63..0.
  - mod_data=frame[bit_idx], held for exactly BIT_CYCLES cycles; bit_strobe pulses when cyc_cnt=0.
  - After the last cycle of bit 0:
    - repeat_en=1 → GAP.
    - Otherwise → IDLE, with done=1 for one cycle, and mod_enable=0 and busy=0 in that same cycle.
  - One frame is exactly 64*BIT_CYCLES cycles of mod_enable=1.
- GAP:
  - mod_enable=0 and mod_data=0 for GAP_BITS*BIT_CYCLES cycles, then re-enter SEND with the same latched frame (bit 63).
  - repeat_en is sampled at each frame end. If repeat_en=0 when the gap ends → IDLE with a done pulse.
- start while busy: ignored. id_data changes while busy do not affect the frame in flight.
- abort=1 in any state → next cycle IDLE; mod_enable, mod_data, busy and bit_strobe = 0; no done pulse. Counters are cleared.
- start and abort asserted together in IDLE → abort wins; start is not accepted.
- start in the same cycle done is asserted: accepted (the FSM is already in IDLE that cycle); the next frame begins one cycle later.
- Reset mid-frame: outputs drop immediately (async). After rst deasserts, the block stays in IDLE until a new start.

Test Plan:
- id_data=40'h0, start pulse, BIT_CYCLES=16 → frame 64'hFF80_0000_0000_0000 on mod_data; mod_enable high for 1024 cycles; 64 bit_strobes; done at cycle 1025.
- id_data=40'h00_0000_0001 → frame 64'hFF80_0000_0000_0062; check row-9 parity bit and c0 bit independently.
- id_data=40'hFF_FFFF_FFFF → all row parities 0, all column parities 0 (10 ones per column); low bits = 0, header intact.
- repeat_en=1 for two frames, then cleared → two identical frames separated by 64 cycles (GAP_BITS=4) of mod_enable=0; exactly one done pulse, after the 2nd frame.
- abort at bit 20 → mod_enable=0 next cycle, busy=0, no done; a fresh start afterwards sends a complete frame from bit 63.
- rst pulse mid-frame, plus start while busy → outputs clear asynchronously; a start during busy does not restart or alter the frame.
